// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: routes MEM-stage accesses to the internal data RAM or an external req/ack bus with timeout.
module mem_access_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] acc_addr,
  input  logic [15:0] acc_wdata,
  input  logic        acc_rd,
  input  logic        acc_wr,
  output logic [15:0] acc_rdata,
  output logic        stall,
  output logic        bus_err,
  output logic [15:0] mem_access_addr,
  output logic [15:0] mem_write_data,
  output logic        mem_write_en,
  input  logic [15:0] mem_read_data,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [15:0] ext_wdata,
  input  logic [15:0] ext_rdata,
  input  logic        ext_ack
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_inc;
  logic [15:0] result;
  logic ext, tmo;
  assign ext = (acc_rd | acc_wr) & acc_addr[15];
  assign cnt_inc = cnt + CNT_WIDTH'(1);
  assign tmo = cnt_inc == CNT_WIDTH'(TIMEOUT);
  assign mem_access_addr = acc_addr;
  assign mem_write_data = acc_wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (ext ? REQ : IDLE) :
               state == REQ  ? ((ext_ack | tmo) ? DONE : REQ) : IDLE;
    stall = (state == IDLE && ext) || state == REQ;
    mem_write_en = state == IDLE && acc_wr && !acc_addr[15];
    acc_rdata = state == DONE ? result : mem_read_data;
  end
  // ack has priority over a coinciding timeout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ext_req <= 1'b0;
      ext_we <= 1'b0;
      ext_addr <= '0;
      ext_wdata <= '0;
      result <= '0;
      cnt <= '0;
      bus_err <= 1'b0;
    end else if (state == IDLE) begin
      bus_err <= 1'b0;
      if (ext) begin
        ext_req <= 1'b1;
        ext_we <= acc_wr;
        ext_addr <= acc_addr;
        ext_wdata <= acc_wdata;
        cnt <= '0;
      end
    end else if (state == REQ) begin
      cnt <= cnt_inc;
      if (ext_ack) begin
        result <= ext_we ? 16'h0000 : ext_rdata;
        ext_req <= 1'b0;
      end else if (tmo) begin
        result <= 16'hFFFF;
        bus_err <= 1'b1;
        ext_req <= 1'b0;
      end
    end else bus_err <= 1'b0;
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sits between the MEM pipeline stage and the on-chip data RAM. It decodes each load/store address.
- Internal region (addr[15]=0): forwarded to the data RAM with zero added latency.
- External region (addr[15]=1): run as a req/ack transaction on an external memory bus. The pipeline is stalled until the transaction completes or times out.

Parameters:
TIMEOUT, 255, max cycles waiting for ext_ack in REQ before abort (1..255)
CNT_WIDTH, 8, width of the timeout counter; must satisfy 2**CNT_WIDTH > TIMEOUT

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous reset, active-high
acc_addr  input  16  access address from MEM stage
acc_wdata  input  16  store data from MEM stage
acc_rd  input  1  load request
acc_wr  input  1  store request
acc_rdata  output  16  load result to MEM/WB
stall  output  1  freeze pipeline (MEM and earlier)
bus_err  output  1  one-cycle pulse: external access timed out
mem_access_addr  output  16  to data RAM address
mem_write_data  output  16  to data RAM write data
mem_write_en  output  1  to data RAM write enable
mem_read_data  input  16  from data RAM (combinational read)
ext_req  output  1  external bus request, registered
ext_we  output  1  external write (1) / read (0), valid with ext_req
ext_addr  output  16  external address, valid with ext_req
ext_wdata  output  16  external write data, valid with ext_req
ext_rdata  input  16  external read data, sampled when ext_ack=1
ext_ack  input  1  external completion, one or more cycles

Behaviour:
- Decoding:
  - access = acc_rd | acc_wr.
  - ext = access & acc_addr[15].
  - Both acc_rd and acc_wr set: treated as a store.
- Internal path, state IDLE, addr[15]=0:
  - mem_access_addr = acc_addr; mem_write_data = acc_wdata.
  - mem_write_en = acc_wr.
  - acc_rdata = mem_read_data; stall = 0.
  - The RAM write occurs on the same clk edge.
- mem_access_addr and mem_write_data always mirror acc_addr and acc_wdata.
- mem_write_en is 0 in every state except IDLE and whenever addr[15]=1.
- FSM states: IDLE, REQ, DONE.
  - IDLE:
    - ext=1 → stall=1 combinationally in the same cycle.
    - On the edge: latch addr/wdata/we into ext_* registers, set ext_req=1, clear counter, go to REQ.
  - REQ:
    - stall=1; ext_req held at 1 with stable ext_addr, ext_we and ext_wdata.
    - Counter increments every cycle.
    - ext_ack=1: capture ext_rdata into the result register (reads only; writes capture 16'h0000), ext_req→0, go to DONE.
    - Counter reaches TIMEOUT with no ack: result=16'hFFFF, bus_err=1 for exactly the DONE cycle, ext_req→0, go to DONE.
    - ack and timeout in the same cycle: ack wins, no bus_err.
  - DONE:
    - stall=0; acc_rdata = result register.
    - The pipeline advances on this edge.
    - The still-present request inputs are ignored: no re-issue, mem_write_en=0.
    - Go to IDLE.
- ext_ack while in IDLE or DONE is ignored.
- Latency:
  - Internal access: 0 stall cycles.
  - External access: 2 + N stall cycles, where N = cycles of ext_ack latency after ext_req rises (ack on the first REQ cycle → N=0).
- Reset (asynchronous, any state, including mid-transaction):
  - State=IDLE; ext_req=0, ext_we=0.
  - ext_addr=0, ext_wdata=0, result=0, counter=0.
  - bus_err=0; stall evaluates to 0 unless an ext access is presented.
  - An aborted transaction is not resumed.
- acc_rdata in IDLE with no access: mem_read_data.

Test Plan:
1. Internal store then load: acc_wr=1, addr=16'h0004, wdata=16'hBEEF; next cycle acc_rd=1 same addr → mem_write_en=1 for one cycle, stall never 1, acc_rdata=16'hBEEF.
2. External load: acc_rd=1, addr=16'h8010; ext_ack driven 3 cycles after ext_req rises, ext_rdata=16'h1234 → ext_req=1 with ext_we=0 and ext_addr=16'h8010; stall high 5 cycles; acc_rdata=16'h1234 in DONE; exactly one ext_req pulse train.
3. External store: acc_wr=1, addr=16'hC000, wdata=16'hA5A5, ack on the first REQ cycle → ext_we=1, ext_wdata=16'hA5A5; stall high 2 cycles; mem_write_en never 1.
4. Timeout: TIMEOUT=4, ext read, no ack → ext_req drops after 4 REQ cycles; bus_err high exactly 1 cycle; acc_rdata=16'hFFFF.
5. Reset mid-REQ: assert rst asynchronously between edges during REQ → ext_req and stall drop immediately; after release, an internal load proceeds with 0 stall.
6. Simultaneous acc_rd=acc_wr=1 at external addr → ext_we=1 (store priority).
